// File: rtl/alu_wb_stage.sv
// Execute-to-writeback pipeline register behind the 32-bit ALU.
// It captures the ALU result, keeps the architectural Z/N flags, resolves
// conditional branches against those flags and counts retired instructions.
// Stage control at each edge: reset > stall (hold) > flush/bubble (squash) > capture.
module alu_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 6,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              set_flags,
  input  logic [REG_AW-1:0] rd,
  input  logic              reg_wr,
  input  logic [1:0]        br_type,
  input  logic [DATA_W-1:0] br_target,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_z,
  output logic              flag_n,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_pc,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic              wb_valid_q, wb_valid_d;
  logic              wb_we_q, wb_we_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_n_q, flag_n_d;
  logic              br_taken_q, br_taken_d;
  logic [DATA_W-1:0] br_pc_q, br_pc_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
  logic              br_cond;

  // Branch condition uses the registered flags, never this instruction's ALU flags.
  always_comb begin
    br_cond = 1'b0;
    case (br_type)
      2'b01:   br_cond = 1'b1;
      2'b10:   br_cond = flag_z_q;
      2'b11:   br_cond = flag_n_q;
      default: br_cond = 1'b0;
    endcase
  end

  // Next-state: hold on stall, squash on flush or bubble, otherwise capture.
  always_comb begin
    wb_valid_d   = wb_valid_q;
    wb_we_d      = wb_we_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    flag_z_d     = flag_z_q;
    flag_n_d     = flag_n_q;
    br_taken_d   = 1'b0;  // redirect is a single-cycle pulse, never held
    br_pc_d      = br_pc_q;
    retire_cnt_d = retire_cnt_q;
    if (stall) begin
      // everything except br_taken holds; a pending flush waits for the hazard unit
    end else if (flush || !in_valid) begin
      wb_valid_d = 1'b0;
      wb_we_d    = 1'b0;
    end else begin
      wb_valid_d   = 1'b1;
      wb_we_d      = reg_wr;
      wb_rd_d      = rd;
      wb_data_d    = alu_out;
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
      if (set_flags) begin
        flag_z_d = alu_z;
        flag_n_d = alu_n;
      end
      if (br_cond) begin
        br_taken_d = 1'b1;
        br_pc_d    = br_target;
      end
    end
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      flag_z_q     <= 1'b0;
      flag_n_q     <= 1'b0;
      br_taken_q   <= 1'b0;
      br_pc_q      <= '0;
      retire_cnt_q <= '0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      flag_z_q     <= flag_z_d;
      flag_n_q     <= flag_n_d;
      br_taken_q   <= br_taken_d;
      br_pc_q      <= br_pc_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign flag_z     = flag_z_q;
  assign flag_n     = flag_n_q;
  assign br_taken   = br_taken_q;
  assign br_pc      = br_pc_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Bench for alu_wb_stage: directed scenarios plus random traffic, with
// expected outputs queued by the driver and checked by an independent monitor.
module tb_alu_wb_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 6;
  localparam int CNT_W  = 4;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [DATA_W-1:0] alu_out = '0;
  logic              alu_z = 1'b0, alu_n = 1'b0, set_flags = 1'b0;
  logic [REG_AW-1:0] rd = '0;
  logic              reg_wr = 1'b0;
  logic [1:0]        br_type = '0;
  logic [DATA_W-1:0] br_target = '0;
  logic              wb_valid, wb_we, flag_z, flag_n, br_taken;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data, br_pc;
  logic [CNT_W-1:0]  retire_cnt;

  alu_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .set_flags(set_flags),
    .rd(rd), .reg_wr(reg_wr), .br_type(br_type), .br_target(br_target),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_z(flag_z), .flag_n(flag_n), .br_taken(br_taken), .br_pc(br_pc),
    .retire_cnt(retire_cnt)
  );

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              fz;
    logic              fn;
    logic              taken;
    logic [DATA_W-1:0] pc;
    logic              pc_known;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;  // reference model of the architectural state after the next edge
  int checks = 0;
  int errors = 0;

  // Reference model: architectural rules applied to one clock edge.
  task automatic model_step();
    logic cond;
    if (!rst_n) begin
      m = '0;
      m.pc_known = 1'b1;
    end else if (stall) begin
      m.taken = 1'b0;
    end else if (flush || !in_valid) begin
      m.valid = 1'b0;
      m.we = 1'b0;
      m.taken = 1'b0;
      m.pc_known = 1'b0;  // redirect address is unspecified after a squash
    end else begin
      cond = (br_type == 2'd1) || (br_type == 2'd2 && m.fz) || (br_type == 2'd3 && m.fn);
      m.valid = 1'b1;
      m.we = reg_wr;
      m.rd = rd;
      m.data = alu_out;
      m.cnt = CNT_W'((int'(m.cnt) + 1) % (1 << CNT_W));
      m.taken = cond;
      if (cond) begin
        m.pc = br_target;
        m.pc_known = 1'b1;
      end
      if (set_flags) begin
        m.fz = alu_z;
        m.fn = alu_n;
      end
    end
    exp_q.push_back(m);
  endtask

  // driver: apply one cycle of stimulus on the falling edge and queue its expectation
  task automatic drive(input logic r, input logic iv, input logic st, input logic fl,
                       input logic [DATA_W-1:0] ao, input logic z, input logic n,
                       input logic sf, input logic [REG_AW-1:0] d, input logic w,
                       input logic [1:0] bt, input logic [DATA_W-1:0] tgt);
    @(negedge clk);
    rst_n = r; in_valid = iv; stall = st; flush = fl;
    alu_out = ao; alu_z = z; alu_n = n; set_flags = sf;
    rd = d; reg_wr = w; br_type = bt; br_target = tgt;
    model_step();
  endtask

  task automatic drive_nop();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 2'd0, '0);
  endtask

  task automatic drive_rand(input int stall_pct, input int flush_pct);
    drive(1'b1, ($urandom_range(0, 99) >= 10), ($urandom_range(0, 99) < stall_pct),
          ($urandom_range(0, 99) < flush_pct), $urandom(), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), REG_AW'($urandom()),
          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom());
  endtask

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // scoreboard monitor: after every active edge, compare outputs with the oldest expectation
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("wb_valid", DATA_W'(wb_valid), DATA_W'(e.valid));
      check("wb_we", DATA_W'(wb_we), DATA_W'(e.we));
      check("flag_z", DATA_W'(flag_z), DATA_W'(e.fz));
      check("flag_n", DATA_W'(flag_n), DATA_W'(e.fn));
      check("br_taken", DATA_W'(br_taken), DATA_W'(e.taken));
      check("retire_cnt", DATA_W'(retire_cnt), DATA_W'(e.cnt));
      if (e.valid) begin
        check("wb_rd", DATA_W'(wb_rd), DATA_W'(e.rd));
        check("wb_data", wb_data, e.data);
      end
      if (e.pc_known) check("br_pc", br_pc, e.pc);
    end
  end

  initial begin
    m = '0;
    // reset held for two cycles
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h1234, 1'b1, 1'b1, 1'b1, 6'd9, 1'b1, 2'd1, 32'h80);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 2'd0, '0);
    // basic capture
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h5, 1'b0, 1'b0, 1'b1, 6'd3, 1'b1, 2'd0, '0);
    // flag-setting A, then branch-if-Z B, then branch-if-N with N clear
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd4, 1'b1, 2'd0, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h7, 1'b0, 1'b0, 1'b0, 6'd5, 1'b0, 2'd2, 32'h40);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 1'b0, 1'b0, 1'b0, 6'd6, 1'b1, 2'd3, 32'h99);
    // unconditional branch into a stall: the pulse must not repeat
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 6'd7, 1'b1, 2'd1, 32'h100);
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b1, 1'b1, 1'b1, $urandom(), 1'b1, 1'b0, 1'b1, REG_AW'($urandom()),
            1'b1, 2'd1, $urandom());
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h55, 1'b1, 1'b1, 1'b1, 6'd8, 1'b1, 2'd1, 32'h200);
    // clear Z, then branch-if-Z that also sets Z: the old flag decides
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 1'b0, 1'b1, 6'd1, 1'b1, 2'd0, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd2, 1'b0, 2'd2, 32'h300);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h2, 1'b0, 1'b0, 1'b0, 6'd3, 1'b1, 2'd2, 32'h340);
    drive_nop();
    // random traffic
    for (int i = 0; i < 300; i++) drive_rand(12, 10);
    // counter wrap: reset, 16 retirements, then reset on a taken branch
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 2'd0, '0);
    for (int i = 0; i < 16; i++)
      drive(1'b1, 1'b1, 1'b0, 1'b0, $urandom(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b1, REG_AW'(i), 1'b1, 2'd0, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hA, 1'b0, 1'b0, 1'b0, 6'd10, 1'b1, 2'd0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'hB, 1'b1, 1'b1, 1'b1, 6'd11, 1'b1, 2'd1, 32'h400);
    drive_nop();
    drive_nop();
    // bounded drain of the expectation queue
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Execute-to-writeback pipeline register that sits directly downstream of the 32-bit ALU (add/inc/neg/sub datapath with Z/N outputs).
- Captures the ALU result and flags, holds an architectural Z/N flag register, and resolves conditional branches against that flag register.
- Drives register-file writeback and the PC-redirect request.
- Supports stall (hold) and flush (squash) from the hazard unit.

Parameters:
- DATA_W, 32, width of ALU result, write data and branch target.
- REG_AW, 6, register-file address width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  execute stage holds a valid instruction
- stall  in  1  hold all stage registers
- flush  in  1  squash the instruction being captured
- alu_out  in  DATA_W  ALU result
- alu_z  in  1  ALU zero flag
- alu_n  in  1  ALU negative flag
- set_flags  in  1  instruction updates the architectural Z/N flags
- rd  in  REG_AW  destination register
- reg_wr  in  1  instruction writes rd
- br_type  in  2  branch type: 00 none, 01 unconditional, 10 branch-if-Z, 11 branch-if-N
- br_target  in  DATA_W  branch destination address
- wb_valid  out  1  writeback stage holds a valid instruction
- wb_we  out  1  register-file write enable (wb_valid & captured reg_wr)
- wb_rd  out  REG_AW  writeback address
- wb_data  out  DATA_W  writeback data
- flag_z  out  1  architectural zero flag
- flag_n  out  1  architectural negative flag
- br_taken  out  1  PC redirect request, one-cycle pulse
- br_pc  out  DATA_W  redirect address
- retire_cnt  out  CNT_W  count of retired valid instructions

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, including flags and retire_cnt. Reset has priority over flush and stall, and an in-flight instruction is discarded.
- Priority at each edge: reset > stall > flush > normal capture.
- Latency: one cycle. The instruction presented at edge k appears on the wb_* outputs after edge k.
- Stall=1:
  - wb_*, flags, br_pc and retire_cnt hold their values.
  - br_taken is forced to 0, so a redirect is never repeated.
  - Flush is ignored while stall=1; the hazard unit reasserts it later.
- Flush=1 (stall=0): wb_valid←0, wb_we←0, br_taken←0. The flags and retire_cnt are not updated. wb_data, wb_rd and br_pc may hold any value.
- Normal capture with in_valid=1:
  - wb_valid←1, wb_data←alu_out, wb_rd←rd, wb_we←reg_wr.
  - retire_cnt increments by 1 and wraps from 2^CNT_W-1 to 0.
- Normal capture with in_valid=0: behaves as a flush (bubble).
- Flag register:
  - On a valid capture with set_flags=1: flag_z←alu_z, flag_n←alu_n.
  - Otherwise the flags hold.
- Branch resolution:
  - Evaluated combinationally from the current flag_z/flag_n (flags from the previous flag-setting instruction, never alu_z/alu_n of the same instruction) and registered at the capture edge.
  - Taken condition: 01 always; 10 if flag_z=1; 11 if flag_n=1; 00 never.
  - On a taken valid capture: br_taken←1 for exactly one cycle and br_pc←br_target.
  - On a not-taken capture: br_taken←0 and br_pc holds.
- Same instruction with set_flags=1 and br_type≠00: the branch uses the old flags, and the flags update at the same edge.
- Branch instructions may also write rd (link); wb_we follows reg_wr independently of the branch outcome.

Test Plan:
- Reset and basic capture:
  - Stimulus: hold rst_n=0 for 2 cycles, then apply in_valid=1, alu_out=0x0000_0005, rd=3, reg_wr=1, set_flags=1, alu_z=0, alu_n=0.
  - Response: all outputs 0 during reset; one cycle later wb_valid=1, wb_we=1, wb_rd=3, wb_data=5, flag_z=0, retire_cnt=1.
- Flag-based branch:
  - Stimulus: instruction A with set_flags=1, alu_out=0, alu_z=1; next cycle instruction B with br_type=10, br_target=0x40, set_flags=0.
  - Response: flag_z=1 after A; br_taken=1 with br_pc=0x40 for exactly one cycle after B. Repeat with br_type=11 and flag_n=0 → br_taken=0.
- Stall and flush:
  - Stimulus: capture alu_out=0xDEAD_BEEF, then stall=1 for 3 cycles with changing inputs and flush=1 also asserted, then flush=1 with stall=0.
  - Response: wb_data holds 0xDEAD_BEEF and br_taken=0 throughout the stall; after the flush wb_valid=0, wb_we=0, and flags and retire_cnt are unchanged.
- Same-cycle branch and flag update:
  - Stimulus: flag_z=0; apply br_type=10 with set_flags=1, alu_z=1.
  - Response: br_taken=0 (old flag used), then flag_z=1.
- Counter wrap and mid-operation reset:
  - Stimulus: CNT_W=4, retire 16 valid instructions; then assert rst_n=0 on the same edge as a taken branch (br_type=01).
  - Response: retire_cnt goes 15→0; after the reset edge all outputs are 0 and br_taken never pulses.
